// File: rtl/ysyx_22050550_divider_pkg.sv
// Shared constants and state encoding for the EXU radix-2 restoring divider.
package ysyx_22050550_divider_pkg;

    localparam int DIV_XLEN = 64;
    localparam int DIV_WLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Sign-extend a W-width value to the full register width.
    function automatic logic [DIV_XLEN-1:0] sext_w(input logic [DIV_WLEN-1:0] v);
        return {{(DIV_XLEN-DIV_WLEN){v[DIV_WLEN-1]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22050550_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift the quotient bit in.
module ysyx_22050550_div_step #(
    parameter int W = 64
) (
    input  logic [W:0]   rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] dsr,
    output logic [W:0]   rem_next,
    output logic [W-1:0] quo_next
);

    logic [W+1:0] rem_shift_s;
    logic [W+1:0] diff_s;
    logic         ge_s;
    logic         unused_top_s;

    assign rem_shift_s  = {rem, quo[W-1]};
    assign diff_s       = rem_shift_s - {2'b00, dsr};
    assign ge_s         = rem_shift_s >= {2'b00, dsr};
    assign rem_next     = ge_s ? diff_s[W:0] : rem_shift_s[W:0];
    assign quo_next     = {quo[W-2:0], ge_s};
    // The remainder never exceeds the divisor, so the top bit is always zero.
    assign unused_top_s = diff_s[W+1] ^ rem_shift_s[W+1];

endmodule

// File: rtl/ysyx_22050550_divider.sv
// Iterative radix-2 restoring divider for RV64M DIV/REM families, including
// the W variants; quotient and remainder are produced together.
module ysyx_22050550_divider
    import ysyx_22050550_divider_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_Exu_DivValid,
    input  logic            io_Exu_Flush,
    input  logic            io_Exu_Divw,
    input  logic            io_Exu_DivSigned,
    input  logic [XLEN-1:0] io_Exu_Dividend,
    input  logic [XLEN-1:0] io_Exu_Divisor,
    output logic            io_Exu_DivReady,
    output logic            io_Exu_OutValid,
    output logic [XLEN-1:0] io_Exu_Quotient,
    output logic [XLEN-1:0] io_Exu_Remainder
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    div_state_e        state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [XLEN:0]     rem_r;
    logic [XLEN-1:0]   quo_r;
    logic [XLEN-1:0]   dsr_r;
    logic              divw_r, q_neg_r, r_neg_r;
    logic [XLEN-1:0]   quotient_r, remainder_r;

    logic              accept_s;
    logic [XLEN-1:0]   dividend_ext_s, divisor_ext_s;
    logic              dividend_neg_s, divisor_neg_s;
    logic [XLEN-1:0]   dividend_mag_s, divisor_mag_s;
    logic [XLEN-1:0]   dividend_res_s;
    logic              div_zero_s, overflow_s, special_s;
    logic [XLEN-1:0]   spec_quo_s, spec_rem_s;
    logic [XLEN:0]     rem_nxt_s;
    logic [XLEN-1:0]   quo_nxt_s;
    logic [XLEN-1:0]   q_mag_s, q_sgn_s, r_sgn_s;
    logic [XLEN-1:0]   quo_fin_s, rem_fin_s;

    assign accept_s = (state_r == ST_IDLE) && io_Exu_DivValid && !io_Exu_Flush;

    // W operands use only the low half, extended according to signedness.
    assign dividend_ext_s = io_Exu_Divw
        ? (io_Exu_DivSigned ? sext_w(io_Exu_Dividend[DIV_WLEN-1:0])
                            : {{(XLEN-DIV_WLEN){1'b0}}, io_Exu_Dividend[DIV_WLEN-1:0]})
        : io_Exu_Dividend;
    assign divisor_ext_s = io_Exu_Divw
        ? (io_Exu_DivSigned ? sext_w(io_Exu_Divisor[DIV_WLEN-1:0])
                            : {{(XLEN-DIV_WLEN){1'b0}}, io_Exu_Divisor[DIV_WLEN-1:0]})
        : io_Exu_Divisor;

    assign dividend_neg_s = io_Exu_DivSigned & dividend_ext_s[XLEN-1];
    assign divisor_neg_s  = io_Exu_DivSigned & divisor_ext_s[XLEN-1];
    assign dividend_mag_s = dividend_neg_s ? -dividend_ext_s : dividend_ext_s;
    assign divisor_mag_s  = divisor_neg_s  ? -divisor_ext_s  : divisor_ext_s;

    assign dividend_res_s = io_Exu_Divw ? sext_w(io_Exu_Dividend[DIV_WLEN-1:0]) : io_Exu_Dividend;
    assign div_zero_s     = (divisor_ext_s == {XLEN{1'b0}});
    assign overflow_s     = io_Exu_DivSigned && (io_Exu_Divw
        ? ((io_Exu_Dividend[DIV_WLEN-1:0] == 32'h8000_0000) &&
           (io_Exu_Divisor[DIV_WLEN-1:0]  == 32'hFFFF_FFFF))
        : ((io_Exu_Dividend == {1'b1, {(XLEN-1){1'b0}}}) &&
           (io_Exu_Divisor  == {XLEN{1'b1}})));
    assign special_s      = div_zero_s || overflow_s;
    assign spec_quo_s     = div_zero_s ? {XLEN{1'b1}} : dividend_res_s;
    assign spec_rem_s     = div_zero_s ? dividend_res_s : {XLEN{1'b0}};

    ysyx_22050550_div_step #(
        .W (XLEN)
    ) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .dsr      (dsr_r),
        .rem_next (rem_nxt_s),
        .quo_next (quo_nxt_s)
    );

    // Final step result, sign-corrected and W-extended, ready for DONE entry.
    assign q_mag_s   = divw_r ? {{(XLEN-DIV_WLEN){1'b0}}, quo_nxt_s[DIV_WLEN-1:0]} : quo_nxt_s;
    assign q_sgn_s   = q_neg_r ? -q_mag_s : q_mag_s;
    assign r_sgn_s   = r_neg_r ? -rem_nxt_s[XLEN-1:0] : rem_nxt_s[XLEN-1:0];
    assign quo_fin_s = divw_r ? sext_w(q_sgn_s[DIV_WLEN-1:0]) : q_sgn_s;
    assign rem_fin_s = divw_r ? sext_w(r_sgn_s[DIV_WLEN-1:0]) : r_sgn_s;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; special cases skip the iteration entirely.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (special_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (io_Exu_Flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == CNT_W'(1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Operand latches, iteration registers and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r       <= {CNT_W{1'b0}};
            rem_r       <= {(XLEN+1){1'b0}};
            quo_r       <= {XLEN{1'b0}};
            dsr_r       <= {XLEN{1'b0}};
            divw_r      <= 1'b0;
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
            quotient_r  <= {XLEN{1'b0}};
            remainder_r <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        divw_r  <= io_Exu_Divw;
                        q_neg_r <= dividend_neg_s ^ divisor_neg_s;
                        r_neg_r <= dividend_neg_s;
                        cnt_r   <= io_Exu_Divw ? CNT_W'(DIV_WLEN) : CNT_W'(XLEN);
                        rem_r   <= {(XLEN+1){1'b0}};
                        // W magnitudes sit in the top half so the MSB-first shift sees them first.
                        quo_r   <= io_Exu_Divw
                            ? {dividend_mag_s[DIV_WLEN-1:0], {(XLEN-DIV_WLEN){1'b0}}}
                            : dividend_mag_s;
                        dsr_r   <= divisor_mag_s;
                        if (special_s) begin
                            quotient_r  <= spec_quo_s;
                            remainder_r <= spec_rem_s;
                        end
                    end
                end
                ST_BUSY: begin
                    if (io_Exu_Flush) begin
                        cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        rem_r <= rem_nxt_s;
                        quo_r <= quo_nxt_s;
                        cnt_r <= cnt_r - CNT_W'(1);
                        if (cnt_r == CNT_W'(1)) begin
                            quotient_r  <= quo_fin_s;
                            remainder_r <= rem_fin_s;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_Exu_DivReady  = (state_r == ST_IDLE);
    assign io_Exu_OutValid  = (state_r == ST_DONE) && !io_Exu_Flush;
    assign io_Exu_Quotient  = quotient_r;
    assign io_Exu_Remainder = remainder_r;

endmodule

// File: tb/tb_ysyx_22050550_divider.sv
// Self-checking bench for ysyx_22050550_divider: a scoreboard of expected
// quotient/remainder/latency is filled at issue and drained at OutValid.
module tb_ysyx_22050550_divider;

    typedef struct {
        logic        w;
        logic        s;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
        int          c;
    } op_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid, flush, divw, dsigned;
    logic [63:0] dividend, divisor;
    logic        ready, outvalid;
    logic [63:0] quo, rem;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          ov_count = 0;
    logic [63:0] exp_q_q[$];
    logic [63:0] exp_r_q[$];
    int          exp_c_q[$];
    logic [63:0] prev_q, prev_r;

    ysyx_22050550_divider #(.XLEN(64)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_Exu_DivValid  (valid),
        .io_Exu_Flush     (flush),
        .io_Exu_Divw      (divw),
        .io_Exu_DivSigned (dsigned),
        .io_Exu_Dividend  (dividend),
        .io_Exu_Divisor   (divisor),
        .io_Exu_DivReady  (ready),
        .io_Exu_OutValid  (outvalid),
        .io_Exu_Quotient  (quo),
        .io_Exu_Remainder (rem)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (outvalid === 1'b1) ov_count <= ov_count + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model built from native SV arithmetic.
    function automatic void ref_div(input logic w, input logic s, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] q,
                                    output logic [63:0] r, output int c);
        logic [31:0] a32, b32, q32, r32;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            c = 33;
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF; r32 = a32; c = 1;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 32'd0; c = 1;
            end else if (s) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            c = 65;
            if (b == 64'd0) begin
                q = {64{1'b1}}; r = a; c = 1;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) begin
                q = a; r = 64'd0; c = 1;
            end else if (s) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    // Drive one request at the current point (caller sits at a negedge).
    task automatic issue(input logic w, input logic s, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] eq, input logic [63:0] er, input int ec);
        exp_q_q.push_back(eq);
        exp_r_q.push_back(er);
        exp_c_q.push_back(ec);
        valid = 1'b1; divw = w; dsigned = s; dividend = a; divisor = b;
        @(posedge clock);
        #1;
        valid    = 1'b0;
        divw     = 1'($urandom);
        dsigned  = 1'($urandom);
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
    endtask

    // Wait (bounded) for OutValid, counting cycles from the accept cycle.
    task automatic collect(input int start, output logic [63:0] oq, output logic [63:0] orr,
                           output int oc, output bit seen, output logic [63:0] eq,
                           output logic [63:0] er, output int ec);
        seen = 1'b0; oq = 64'd0; orr = 64'd0; oc = 0;
        for (int i = start + 1; i <= 100; i++) begin
            @(negedge clock);
            if (outvalid === 1'b1) begin
                seen = 1'b1; oq = quo; orr = rem; oc = i;
                break;
            end
        end
        eq = exp_q_q.pop_front();
        er = exp_r_q.pop_front();
        ec = exp_c_q.pop_front();
    endtask

    task automatic drop_expected();
        logic [63:0] d64;
        int          d32;
        d64 = exp_q_q.pop_front();
        d64 = exp_r_q.pop_front();
        d32 = exp_c_q.pop_front();
    endtask

    task automatic test_reset();
        reset = 1'b1; valid = 1'b0; flush = 1'b0; divw = 1'b0; dsigned = 1'b0;
        dividend = 64'd0; divisor = 64'd0;
        #2;
        n_checks++;
        if (ready !== 1'b1 || outvalid !== 1'b0 || quo !== 64'd0 || rem !== 64'd0) begin
            n_fails++;
            $display("FAIL reset: ready=%b ov=%b q=%h r=%h, want 1 0 0 0", ready, outvalid, quo, rem);
        end
        @(negedge clock);
        reset = 1'b0;
        prev_q = 64'd0; prev_r = 64'd0;
    endtask

    task automatic run_table(input string name, input op_t ops[$]);
        logic [63:0] oq, orr, eq, er;
        int          oc, ec;
        bit          seen;
        foreach (ops[i]) begin
            @(negedge clock);
            issue(ops[i].w, ops[i].s, ops[i].a, ops[i].b, ops[i].q, ops[i].r, ops[i].c);
            collect(0, oq, orr, oc, seen, eq, er, ec);
            n_checks++;
            if (!seen || oq !== eq || orr !== er || oc !== ec) begin
                n_fails++;
                $display("FAIL %s[%0d]: got q=%h r=%h cyc=%0d seen=%0b, want q=%h r=%h cyc=%0d",
                         name, i, oq, orr, oc, seen, eq, er, ec);
            end
            @(negedge clock);
            n_checks++;
            if (outvalid !== 1'b0 || ready !== 1'b1) begin
                n_fails++;
                $display("FAIL %s[%0d] after: ov=%b ready=%b, want 0 1", name, i, outvalid, ready);
            end
            prev_q = eq; prev_r = er;
        end
    endtask

    task automatic test_unsigned();
        op_t ops[$];
        ops.push_back(op_t'{1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65});
        run_table("divu", ops);
    endtask

    task automatic test_signed();
        op_t ops[$];
        ops.push_back(op_t'{1'b0, 1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65});
        ops.push_back(op_t'{1'b0, 1'b1, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65});
        run_table("div", ops);
    endtask

    task automatic test_w();
        op_t ops[$];
        ops.push_back(op_t'{1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                            64'hFFFF_FFFF_8000_0000, 64'd0, 1});
        ops.push_back(op_t'{1'b1, 1'b0, 64'h0000_0000_FFFF_FFFE, 64'd1,
                            64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 33});
        ops.push_back(op_t'{1'b1, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_EF01_0000_0002,
                            64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33});
        ops.push_back(op_t'{1'b1, 1'b0, 64'h1234_5678_8000_0001, 64'h0000_0001_0000_0010,
                            64'h0000_0000_0800_0000, 64'd1, 33});
        run_table("w", ops);
    endtask

    task automatic test_div_zero();
        op_t ops[$];
        ops.push_back(op_t'{1'b0, 1'b1, 64'h8000_0000_0000_0000, {64{1'b1}},
                            64'h8000_0000_0000_0000, 64'd0, 1});
        ops.push_back(op_t'{1'b0, 1'b0, 64'd42, 64'd0, {64{1'b1}}, 64'd42, 1});
        ops.push_back(op_t'{1'b1, 1'b1, 64'h0000_0001_8000_0000, 64'd0,
                            {64{1'b1}}, 64'hFFFF_FFFF_8000_0000, 1});
        run_table("divzero", ops);
    endtask

    task automatic test_flush();
        logic [63:0] oq, orr, eq, er;
        int          oc, ec, ov_before;
        bit          seen;
        ov_before = ov_count;
        @(negedge clock);
        issue(1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65);
        drop_expected();
        repeat (9) @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        @(negedge clock);
        n_checks++;
        if (ready !== 1'b1 || outvalid !== 1'b0 || quo !== prev_q || rem !== prev_r) begin
            n_fails++;
            $display("FAIL flush_busy: ready=%b ov=%b q=%h r=%h, want 1 0 %h %h",
                     ready, outvalid, quo, rem, prev_q, prev_r);
        end
        repeat (70) @(negedge clock);
        n_checks++;
        if (ov_count !== ov_before || ready !== 1'b1) begin
            n_fails++;
            $display("FAIL flush_no_result: strobes=%0d ready=%b, want %0d 1", ov_count, ready, ov_before);
        end
        // Flush in IDLE must block acceptance.
        valid = 1'b1; flush = 1'b1; divw = 1'b0; dsigned = 1'b0; dividend = 64'd9; divisor = 64'd3;
        @(posedge clock);
        #1;
        valid = 1'b0; flush = 1'b0;
        @(negedge clock);
        n_checks++;
        if (ready !== 1'b1) begin
            n_fails++;
            $display("FAIL flush_idle: ready=%b, want 1", ready);
        end
        issue(1'b0, 1'b0, 64'd6, 64'd3, 64'd2, 64'd0, 65);
        repeat (30) @(negedge clock);
        n_checks++;
        if (quo !== prev_q || rem !== prev_r || ready !== 1'b0) begin
            n_fails++;
            $display("FAIL flush_hold: q=%h r=%h ready=%b, want %h %h 0", quo, rem, ready, prev_q, prev_r);
        end
        collect(30, oq, orr, oc, seen, eq, er, ec);
        n_checks++;
        if (!seen || oq !== eq || orr !== er || oc !== ec) begin
            n_fails++;
            $display("FAIL flush_next: got q=%h r=%h cyc=%0d, want q=%h r=%h cyc=%0d", oq, orr, oc, eq, er, ec);
        end
        prev_q = eq; prev_r = er;
    endtask

    task automatic test_valid_ignored();
        logic [63:0] oq, orr, eq, er;
        int          oc, ec;
        bit          seen;
        @(negedge clock);
        issue(1'b0, 1'b0, 64'd6, 64'd3, 64'd2, 64'd0, 65);
        valid = 1'b1; divw = 1'b0; dsigned = 1'b0; dividend = 64'd1000; divisor = 64'd1;
        collect(0, oq, orr, oc, seen, eq, er, ec);
        valid = 1'b0;
        n_checks++;
        if (!seen || oq !== eq || orr !== er || oc !== ec) begin
            n_fails++;
            $display("FAIL valid_busy: got q=%h r=%h cyc=%0d, want q=%h r=%h cyc=%0d", oq, orr, oc, eq, er, ec);
        end
        repeat (2) @(negedge clock);
        n_checks++;
        if (ready !== 1'b1 || outvalid !== 1'b0) begin
            n_fails++;
            $display("FAIL valid_not_queued: ready=%b ov=%b, want 1 0", ready, outvalid);
        end
        prev_q = eq; prev_r = er;
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b, eq, er, oq, orr, xq, xr;
        logic        w, s;
        int          ec, oc, xc;
        bit          seen;
        @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            w = 1'($urandom); s = 1'($urandom);
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       b = {$urandom, $urandom};
                1:       b = 64'($urandom_range(1, 100));
                2:       b = {32'($urandom), 32'd0};
                default: b = {64{1'b1}};
            endcase
            if (i == 3) a = 64'h8000_0000_8000_0000;
            ref_div(w, s, a, b, eq, er, ec);
            issue(w, s, a, b, eq, er, ec);
            collect(0, oq, orr, oc, seen, xq, xr, xc);
            n_checks++;
            if (!seen || oq !== xq || orr !== xr || oc !== xc) begin
                n_fails++;
                $display("FAIL b2b[%0d] w=%b s=%b a=%h b=%h: got q=%h r=%h cyc=%0d, want q=%h r=%h cyc=%0d",
                         i, w, s, a, b, oq, orr, oc, xq, xr, xc);
            end
            @(negedge clock);
            n_checks++;
            if (ready !== 1'b1 || outvalid !== 1'b0) begin
                n_fails++;
                $display("FAIL b2b_ready[%0d]: ready=%b ov=%b, want 1 0", i, ready, outvalid);
            end
            prev_q = xq; prev_r = xr;
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] oq, orr, eq, er;
        int          oc, ec;
        bit          seen;
        @(negedge clock);
        issue(1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65);
        drop_expected();
        repeat (19) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (ready !== 1'b1 || outvalid !== 1'b0 || quo !== 64'd0 || rem !== 64'd0) begin
            n_fails++;
            $display("FAIL async_reset: ready=%b ov=%b q=%h r=%h, want 1 0 0 0", ready, outvalid, quo, rem);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        issue(1'b0, 1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        collect(0, oq, orr, oc, seen, eq, er, ec);
        n_checks++;
        if (!seen || oq !== eq || orr !== er || oc !== ec) begin
            n_fails++;
            $display("FAIL after_reset: got q=%h r=%h cyc=%0d, want q=%h r=%h cyc=%0d", oq, orr, oc, eq, er, ec);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_w();
        test_div_zero();
        test_flush();
        test_valid_ignored();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
